// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// Frames are start, DATA_BITS LSB first, optional parity, then STOP_BITS stop bits.
module uart_tx_cfg #(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                                i_Clock,
   input  logic                                i_Reset,
   input  logic                                i_TX_DV,
   input  logic [DATA_BITS-1:0]                i_TX_Data,
   output logic                                o_TX_Ready,
   output logic                                o_TX_Active,
   output logic                                o_TX_Serial,
   output logic                                o_TX_Done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_FIFO_Count
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;
   logic                 ready_q;

   state_e               state_q;
   logic [BAUD_W-1:0]    baud_q;
   logic [BIT_W-1:0]     bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 serial_q;
   logic                 active_q;
   logic                 done_q;

   logic                 push_c;
   logic                 pop_c;
   logic                 nempty_c;
   logic                 baud_end_c;
   logic                 last_data_c;
   logic                 last_stop_c;
   logic [DATA_BITS-1:0] rdata_c;
   logic                 par_bit_c;

   // Writes are gated by the registered ready, so a full FIFO drops them even on a pop edge.
   always_comb begin
      push_c      = i_TX_DV & ready_q;
      nempty_c    = (count_q != '0);
      baud_end_c  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
      last_data_c = (bit_q == BIT_W'(DATA_BITS - 1));
      last_stop_c = (bit_q == BIT_W'(STOP_BITS - 1));
      rdata_c     = mem_q[rd_ptr_q];
      par_bit_c   = (^rdata_c) ^ (PARITY == 1);
      pop_c       = nempty_c & ((state_q == S_IDLE) |
                                ((state_q == S_STOP) & baud_end_c & last_stop_c));
      count_d     = count_q;
      if (push_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge i_Clock) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= i_TX_Data;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
         ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      end
   end

   // Serial engine: the word and its parity are captured at pop time.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pop_c) begin
                  shift_q  <= rdata_c;
                  par_q    <= par_bit_c;
                  baud_q   <= '0;
                  serial_q <= 1'b0;
                  active_q <= 1'b1;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (baud_end_c) begin
                  baud_q   <= '0;
                  bit_q    <= '0;
                  serial_q <= shift_q[0];
                  state_q  <= S_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (baud_end_c) begin
                  baud_q <= '0;
                  if (last_data_c) begin
                     bit_q <= '0;
                     if (PARITY != 0) begin
                        serial_q <= par_q;
                        state_q  <= S_PARITY;
                     end else begin
                        serial_q <= 1'b1;
                        state_q  <= S_STOP;
                     end
                  end else begin
                     bit_q    <= bit_q + BIT_W'(1);
                     shift_q  <= shift_q >> 1;
                     serial_q <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_PARITY: begin
               if (baud_end_c) begin
                  baud_q   <= '0;
                  bit_q    <= '0;
                  serial_q <= 1'b1;
                  state_q  <= S_STOP;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (baud_end_c) begin
                  baud_q <= '0;
                  if (last_stop_c) begin
                     done_q <= 1'b1;
                     bit_q  <= '0;
                     if (pop_c) begin
                        shift_q  <= rdata_c;
                        par_q    <= par_bit_c;
                        serial_q <= 1'b0;
                        state_q  <= S_START;
                     end else begin
                        serial_q <= 1'b1;
                        active_q <= 1'b0;
                        state_q  <= S_IDLE;
                     end
                  end else begin
                     bit_q <= bit_q + BIT_W'(1);
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               serial_q <= 1'b1;
               active_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign o_TX_Ready   = ready_q;
   assign o_TX_Active  = active_q;
   assign o_TX_Serial  = serial_q;
   assign o_TX_Done    = done_q;
   assign o_FIFO_Count = count_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: 8N1 scoreboard instance plus 7E2 and 7O2 instances.
module tb_uart_tx_cfg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst0, rst1, rst2;
   logic       dv0, dv1, dv2;
   logic [7:0] data0;
   logic [6:0] data1, data2;
   logic       rdy0, rdy1, rdy2;
   logic       act0, act1, act2;
   logic       ser0, ser1, ser2;
   logic       done0, done1, done2;
   logic [2:0] cnt0, cnt1, cnt2;

   wire [2:0] ser_v  = {ser2, ser1, ser0};
   wire [2:0] done_v = {done2, done1, done0};
   wire [2:0] act_v  = {act2, act1, act0};
   wire [2:0] rdy_v  = {rdy2, rdy1, rdy0};

   uart_tx_cfg #(.CLKS_PER_BIT(4)) dut0 (
      .i_Clock(clk), .i_Reset(rst0), .i_TX_DV(dv0), .i_TX_Data(data0),
      .o_TX_Ready(rdy0), .o_TX_Active(act0), .o_TX_Serial(ser0),
      .o_TX_Done(done0), .o_FIFO_Count(cnt0));

   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
      .i_Clock(clk), .i_Reset(rst1), .i_TX_DV(dv1), .i_TX_Data(data1),
      .o_TX_Ready(rdy1), .o_TX_Active(act1), .o_TX_Serial(ser1),
      .o_TX_Done(done1), .o_FIFO_Count(cnt1));

   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut2 (
      .i_Clock(clk), .i_Reset(rst2), .i_TX_DV(dv2), .i_TX_Data(data2),
      .o_TX_Ready(rdy2), .o_TX_Active(act2), .o_TX_Serial(ser2),
      .o_TX_Done(done2), .o_FIFO_Count(cnt2));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   logic [9:0] sb_q[$];
   int         starts_q[$];

   // Line monitor for dut0: samples mid-bit and checks done timing against queued frames.
   initial begin : mon0
      logic [9:0] got;
      logic [9:0] exp;
      bit         pend;
      pend = 0;
      forever begin
         if (!pend) @(negedge clk);
         pend = 0;
         if (rst0 === 1'b0 && ser0 === 1'b0) begin
            starts_q.push_back(cyc);
            got = '0;
            repeat (2) @(negedge clk);
            got[0] = ser0;
            for (int k = 1; k < 10; k++) begin
               repeat (4) @(negedge clk);
               got[k] = ser0;
            end
            @(negedge clk);
            chk("done low before frame end", done0, 1'b0);
            @(negedge clk);
            chk("done at frame end", done0, 1'b1);
            chk("frame was queued", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
               exp = sb_q.pop_front();
               chk("frame bits", got, exp);
            end
            pend = 1;
         end
      end
   end

   task automatic drain0();
      bit ok;
      ok = 0;
      for (int t = 0; t < 600; t++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && act0 == 1'b0) begin
            ok = 1;
            break;
         end
      end
      chk("drain dut0", ok, 1'b1);
   endtask

   task automatic capture(input int idx, input int nb, output logic [11:0] bits,
                          output bit found, output logic d_pre, output logic d_at);
      found = 0;
      bits  = '0;
      d_pre = 1'bx;
      d_at  = 1'bx;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (ser_v[idx] == 1'b0) begin
            found = 1;
            break;
         end
      end
      if (found) begin
         repeat (2) @(negedge clk);
         bits[0] = ser_v[idx];
         for (int k = 1; k < nb; k++) begin
            repeat (4) @(negedge clk);
            bits[k] = ser_v[idx];
         end
         @(negedge clk);
         d_pre = done_v[idx];
         @(negedge clk);
         d_at = done_v[idx];
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
   } vec_t;

   vec_t tbl[5];

   initial begin : main
      logic [7:0]  w;
      logic [11:0] bits;
      bit          found, ok, seen;
      logic        d_pre, d_at;

      tbl[0] = '{8'h3F, 10'b1_0011_1111_0};
      tbl[1] = '{8'h00, 10'b1_0000_0000_0};
      tbl[2] = '{8'hFF, 10'b1_1111_1111_0};
      tbl[3] = '{8'hA5, 10'b1_1010_0101_0};
      tbl[4] = '{8'h81, 10'b1_1000_0001_0};

      rst0 = 1; rst1 = 1; rst2 = 1;
      dv0 = 0; dv1 = 0; dv2 = 0;
      data0 = '0; data1 = '0; data2 = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset serial", ser_v[i], 1'b1);
         chk("reset active", act_v[i], 1'b0);
         chk("reset done", done_v[i], 1'b0);
         chk("reset ready", rdy_v[i], 1'b1);
      end
      chk("reset count0", cnt0, 0);
      chk("reset count1", cnt1, 0);
      rst0 = 0; rst1 = 0; rst2 = 0;
      @(negedge clk);

      // Table of single 8N1 frames; first entry also checks write-to-start latency.
      for (int i = 0; i < 5; i++) begin
         data0 = tbl[i].data;
         dv0 = 1;
         sb_q.push_back(tbl[i].frame);
         @(negedge clk);
         dv0 = 0;
         if (i == 0) begin
            chk("count after write", cnt0, 1);
            chk("line idle one edge after write", ser0, 1'b1);
            @(negedge clk);
            chk("start bit two edges after write", ser0, 1'b0);
            chk("active in start", act0, 1'b1);
            chk("count after pop", cnt0, 0);
         end
         drain0();
      end

      // Burst into a full FIFO, then a write held across the pop edge.
      repeat (3) @(negedge clk);
      starts_q.delete();
      for (int i = 0; i < 5; i++) begin
         w = 8'(17 * (i + 1));
         data0 = w;
         dv0 = 1;
         sb_q.push_back({1'b1, w, 1'b0});
         @(negedge clk);
      end
      data0 = 8'hEE;
      chk("ready low when full", rdy0, 1'b0);
      chk("count full", cnt0, 4);
      ok = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (cnt0 != 3'd4) begin
            ok = 1;
            break;
         end
      end
      dv0 = 0;
      chk("pop while full observed", ok, 1'b1);
      chk("count 4->3 on pop with write", cnt0, 3);
      chk("ready after pop", rdy0, 1'b1);
      drain0();
      repeat (60) @(negedge clk);
      chk("burst frame count", starts_q.size(), 5);
      if (starts_q.size() == 5) begin
         for (int i = 1; i < 5; i++) chk("back-to-back gap", starts_q[i] - starts_q[i-1], 40);
      end
      chk("idle after burst", act0, 1'b0);

      // Reset during data bit 3 of a 7E2 frame with words queued behind it.
      data1 = 7'h55; dv1 = 1;
      @(negedge clk);
      data1 = 7'h12;
      @(negedge clk);
      data1 = 7'h34;
      @(negedge clk);
      dv1 = 0;
      chk("7E2 start bit", ser1, 1'b0);
      repeat (16) @(negedge clk);
      chk("7E2 data bit3", ser1, 1'b0);
      chk("count before reset", cnt1, 2);
      #1 rst1 = 1;
      #1;
      chk("abort line high", ser1, 1'b1);
      chk("abort active low", act1, 1'b0);
      chk("abort count cleared", cnt1, 0);
      chk("abort done low", done1, 1'b0);
      @(negedge clk);
      rst1 = 0;
      seen = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (done1 || act1 || ser1 == 1'b0) seen = 1;
      end
      chk("quiet after reset", seen, 1'b0);

      data1 = 7'h55; dv1 = 1;
      @(negedge clk);
      dv1 = 0;
      capture(1, 11, bits, found, d_pre, d_at);
      chk("7E2 start seen", found, 1'b1);
      chk("7E2 frame bits", bits[10:0], 11'b1_1_0_1010101_0);
      chk("7E2 done low at 43", d_pre, 1'b0);
      chk("7E2 done at 44", d_at, 1'b1);

      data2 = 7'h55; dv2 = 1;
      @(negedge clk);
      dv2 = 0;
      capture(2, 11, bits, found, d_pre, d_at);
      chk("7O2 start seen", found, 1'b1);
      chk("7O2 frame bits", bits[10:0], 11'b1_1_1_1010101_0);
      chk("7O2 done low at 43", d_pre, 1'b0);
      chk("7O2 done at 44", d_at, 1'b1);
      repeat (4) @(negedge clk);
      chk("7O2 idle after frame", act2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have the parameter CLKS_PER_BIT, default 217, meaning clocks per serial bit, legal range >= 2.
REQ-002 The block SHALL have the parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-003 The block SHALL have the parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have the parameter STOP_BITS, default 1, meaning stop bits per frame, 1 or 2.
REQ-005 The block SHALL have the parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries, a power of 2, >= 2.
REQ-006 The block SHALL have the port i_Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have the port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have the port i_TX_DV, input, 1 bit: write strobe, one word per cycle while high.
REQ-009 The block SHALL have the port i_TX_Data, input, DATA_BITS wide: the word to transmit, LSB first.
REQ-010 The block SHALL have the port o_TX_Ready, output, 1 bit: high when the FIFO is not full.
REQ-011 The block SHALL have the port o_TX_Active, output, 1 bit: high while a frame is on the line.
REQ-012 The block SHALL have the port o_TX_Serial, output, 1 bit: serial line, idle high.
REQ-013 The block SHALL have the port o_TX_Done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-014 The block SHALL have the port o_FIFO_Count, output, clog2(FIFO_DEPTH+1) bits: number of words queued, excluding the word in flight.

Function
REQ-015 The FIFO SHALL accept i_TX_Data on a rising edge where i_TX_DV=1 and o_TX_Ready=1; a write while full SHALL be dropped with no state change, even if a pop occurs on the same edge.
REQ-016 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; o_FIFO_Count SHALL range from 0 to FIFO_DEPTH.
REQ-017 The engine SHALL use the states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE, if the FIFO is non-empty, the engine SHALL pop one word and enter START on that edge.
- Write-to-start-bit latency is 2 edges from an empty, idle block.
REQ-019 START SHALL drive 0 for exactly CLKS_PER_BIT cycles.
REQ-020 DATA SHALL drive DATA_BITS bits LSB first, each for exactly CLKS_PER_BIT cycles.
REQ-021 PARITY SHALL be entered only when PARITY != 0 and SHALL drive one bit for CLKS_PER_BIT cycles.
- Odd: XOR of data bits inverted; even: XOR of data bits.
REQ-022 STOP SHALL drive 1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 On the last STOP cycle, o_TX_Done SHALL pulse high for exactly one cycle.
- If the FIFO is non-empty, the engine SHALL pop and enter START directly, with zero idle cycles between frames.
- Otherwise it SHALL enter IDLE.
REQ-024 o_TX_Active SHALL be high in every state other than IDLE, and o_TX_Serial SHALL be 1 in IDLE.
REQ-025 The transmitted word SHALL be latched at pop; FIFO writes during a frame SHALL NOT alter the frame in flight.
REQ-026 Total frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.

Reset
REQ-027 While i_Reset=1, the block SHALL be asynchronously in IDLE.
- Outputs: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, o_FIFO_Count=0.
- FIFO pointers and the bit and baud counters are cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (line high) and discard all queued words; no o_TX_Done pulse SHALL occur.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-029 Defaults 8N1: write 0x3F -> line sequence 0, 1,1,1,1,1,1,0,0, 1, each bit 4 cycles; o_TX_Done pulses once, 40 cycles after the start bit begins.
REQ-030 DATA_BITS=7, PARITY=2, STOP_BITS=2: write 0x55 -> 0, 1010101, parity 0, 1, 1; frame 44 cycles; repeat with PARITY=1 -> parity bit 1.
REQ-031 FIFO_DEPTH=4: write 6 words on consecutive cycles -> 5 accepted (1 popped + 4 queued), o_TX_Ready low after the 5th, 6th dropped; 5 frames back-to-back with no idle gap, then o_TX_Active=0.
REQ-032 Pop/write same edge when full: the write is dropped, o_FIFO_Count goes 4->3.
REQ-033 Assert i_Reset during DATA bit 3 -> o_TX_Serial=1 and o_TX_Active=0 immediately, o_FIFO_Count=0, no o_TX_Done pulse; the next write transmits normally.
REQ-034 Loopback with the existing receiver at CLKS_PER_BIT=217, 8N1: bytes 0x00, 0xFF, 0xA5 -> received equal.
